regfile: RTL and testbench

- 32 x 32-bit general-purpose register file for the RV32I core; sits directly downstream of the execute stage.
- Consumes the execute result (result, destination address, write enable) as its write port.
- Provides two combinational read ports to the decode stage, which drives the execute operands.
- Keeps a running count of committed register writes for debug and performance visibility.

---
 rtl/regfile.sv | 82 ++++++++
 tb/tb_regfile.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 32 x 32-bit RV32I general-purpose register file.
// One synchronous write port fed by the execute stage.
// Two combinational read ports feed the decode stage.
// A free-running counter tracks committed writes.
//
// Build option REGFILE_BYPASS_EN:
//   Defined:   a read of the register being written in the same cycle
//              returns the incoming write data (write-through bypass).
//   Undefined: such a read returns the stored value. The new value
//              becomes visible after the clock edge.
// x0 always reads as zero. Writes to x0 never commit and are not counted.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [ADDR_W-1:0] raddr1_in,
  input  logic [ADDR_W-1:0] raddr2_in,
  output logic [DATA_W-1:0] rdata1_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [31:0]       wr_count_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [31:0]       r_wr_count;
  logic              w_commit;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;

  // A write only takes effect when it targets a real register (not x0).
  assign w_commit = we_in && (waddr_in != '0);

  // Register array and commit counter; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_mem[waddr_in] <= wdata_in;
      r_wr_count      <= r_wr_count + 32'd1;
    end
  end

  // Read port 1: x0 reads as zero, with an optional same-cycle bypass.
  always_comb begin
    w_rdata1 = '0;
    if (raddr1_in != '0) begin
      w_rdata1 = r_mem[raddr1_in];
`ifdef REGFILE_BYPASS_EN
      if (w_commit && (raddr1_in == waddr_in)) begin
        w_rdata1 = wdata_in;
      end
`endif
    end
  end

  // Read port 2: same rules as port 1, evaluated independently.
  always_comb begin
    w_rdata2 = '0;
    if (raddr2_in != '0) begin
      w_rdata2 = r_mem[raddr2_in];
`ifdef REGFILE_BYPASS_EN
      if (w_commit && (raddr2_in == waddr_in)) begin
        w_rdata2 = wdata_in;
      end
`endif
    end
  end

  assign rdata1_out   = w_rdata1;
  assign rdata2_out   = w_rdata2;
  assign wr_count_out = r_wr_count;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: self-checking bench for regfile.
// Expected results are pushed to a scoreboard queue when stimulus is driven.
// They are popped and compared once the DUT output is sampled.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_in;
  logic [4:0]  waddr_in;
  logic [31:0] wdata_in;
  logic [4:0]  raddr1_in;
  logic [4:0]  raddr2_in;
  logic [31:0] rdata1_out;
  logic [31:0] rdata2_out;
  logic [31:0] wr_count_out;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  logic [31:0] model_cnt;

  regfile dut (
    .clk          (clk),
    .rst          (rst),
    .we_in        (we_in),
    .waddr_in     (waddr_in),
    .wdata_in     (wdata_in),
    .raddr1_in    (raddr1_in),
    .raddr2_in    (raddr2_in),
    .rdata1_out   (rdata1_out),
    .rdata2_out   (rdata2_out),
    .wr_count_out (wr_count_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_cnt = 32'h0;
  endtask

  task automatic push_exp(input string nm, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] ec);
    exp_t e;
    e.name = nm; e.r1 = e1; e.r2 = e2; e.cnt = ec;
    sb.push_back(e);
  endtask

  // Commit one write through the port and mirror it in the model.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we_in = 1'b1; waddr_in = a; wdata_in = d;
    @(posedge clk);
    #1;
    we_in = 1'b0;
    if (a != 5'd0) begin
      model[a]  = d;
      model_cnt = model_cnt + 32'd1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; we_in = 1'b0; waddr_in = '0; wdata_in = '0;
    raddr1_in = 5'd5; raddr2_in = 5'd0;
    model_clear();
    #1;
    push_exp("reset_init", 32'h0, 32'h0, 32'h0);
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h cnt=%h required r1=%h cnt=%h", e.name, rdata1_out, wr_count_out, e.r1, e.cnt);
    end
    @(negedge clk); rst = 1'b0;
    do_write(5'd5, 32'h1234);
    push_exp("reset_prewrite", 32'h1234, 32'h0, 32'd1);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h cnt=%h required r1=%h cnt=%h", e.name, rdata1_out, wr_count_out, e.r1, e.cnt);
    end
    // Assert reset between edges; the clear must not wait for a clock.
    #1 rst = 1'b1;
    model_clear();
    push_exp("reset_async", 32'h0, 32'h0, 32'h0);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h cnt=%h required r1=%h cnt=%h", e.name, rdata1_out, wr_count_out, e.r1, e.cnt);
    end
    // A write presented while reset is held must be discarded.
    @(negedge clk);
    we_in = 1'b1; waddr_in = 5'd6; wdata_in = 32'hCAFE0006;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; we_in = 1'b0; raddr1_in = 5'd6;
    push_exp("reset_write_dropped", 32'h0, 32'h0, 32'h0);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h cnt=%h required r1=%h cnt=%h", e.name, rdata1_out, wr_count_out, e.r1, e.cnt);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    do_write(5'd3, 32'hDEADBEEF);
    raddr1_in = 5'd3; raddr2_in = 5'd3;
    push_exp("basic_rw", 32'hDEADBEEF, 32'hDEADBEEF, 32'd1);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || rdata2_out !== e.r2 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h r2=%h cnt=%h required r1=%h r2=%h cnt=%h", e.name, rdata1_out, rdata2_out, wr_count_out, e.r1, e.r2, e.cnt);
    end
  endtask

  task automatic test_x0();
    exp_t e;
    // Same-cycle read of x0 while x0 is being written: zero even with bypass.
    @(negedge clk);
    we_in = 1'b1; waddr_in = 5'd0; wdata_in = 32'hFFFFFFFF;
    raddr1_in = 5'd0; raddr2_in = 5'd0;
    push_exp("x0_same_cycle", 32'h0, 32'h0, model_cnt);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || rdata2_out !== e.r2 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h r2=%h cnt=%h required r1=%h r2=%h cnt=%h", e.name, rdata1_out, rdata2_out, wr_count_out, e.r1, e.r2, e.cnt);
    end
    @(posedge clk); #1; we_in = 1'b0;
    push_exp("x0_after_edge", 32'h0, 32'h0, model_cnt);
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || rdata2_out !== e.r2 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h r2=%h cnt=%h required r1=%h r2=%h cnt=%h", e.name, rdata1_out, rdata2_out, wr_count_out, e.r1, e.r2, e.cnt);
    end
  endtask

  task automatic test_hazard();
    exp_t e;
    do_write(5'd7, 32'h11);
    @(negedge clk);
    we_in = 1'b1; waddr_in = 5'd7; wdata_in = 32'h22;
    raddr1_in = 5'd7; raddr2_in = 5'd3;
    push_exp("hazard_same_cycle", BYP ? 32'h22 : 32'h11, 32'hDEADBEEF, model_cnt);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || rdata2_out !== e.r2 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h r2=%h cnt=%h required r1=%h r2=%h cnt=%h", e.name, rdata1_out, rdata2_out, wr_count_out, e.r1, e.r2, e.cnt);
    end
    @(posedge clk); #1; we_in = 1'b0;
    model[7] = 32'h22; model_cnt = model_cnt + 32'd1;
    raddr2_in = 5'd7;
    push_exp("hazard_after_edge", 32'h22, 32'h22, model_cnt);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || rdata2_out !== e.r2 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h r2=%h cnt=%h required r1=%h r2=%h cnt=%h", e.name, rdata1_out, rdata2_out, wr_count_out, e.r1, e.r2, e.cnt);
    end
  endtask

  task automatic test_exec_chain();
    exp_t e;
    logic [31:0] sub_res;
    do_write(5'd2, 32'd3);
    do_write(5'd1, 32'd5);
    raddr1_in = 5'd1; raddr2_in = 5'd2;
    push_exp("exec_sub_operands", 32'd5, 32'd3, model_cnt);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || rdata2_out !== e.r2 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h r2=%h cnt=%h required r1=%h r2=%h cnt=%h", e.name, rdata1_out, rdata2_out, wr_count_out, e.r1, e.r2, e.cnt);
    end
    sub_res = 32'd5 - 32'd3;
    do_write(5'd4, sub_res);
    // Unsupported opcode: execute drives rd_addr=0 with some result.
    do_write(5'd0, 32'h0BAD0BAD);
    raddr1_in = 5'd4; raddr2_in = 5'd1;
    push_exp("exec_unsupported", 32'd2, 32'd5, model_cnt);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || rdata2_out !== e.r2 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h r2=%h cnt=%h required r1=%h r2=%h cnt=%h", e.name, rdata1_out, rdata2_out, wr_count_out, e.r1, e.r2, e.cnt);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic        w;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd, e1, e2;
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      w   = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 7));
      wd  = $urandom;
      ra1 = 5'($urandom_range(0, 7));
      ra2 = (it % 4 == 0) ? wa : 5'($urandom_range(0, 7));
      we_in = w; waddr_in = wa; wdata_in = wd; raddr1_in = ra1; raddr2_in = ra2;
      e1 = (ra1 == 5'd0) ? 32'h0 : ((BYP && w && wa != 5'd0 && wa == ra1) ? wd : model[ra1]);
      e2 = (ra2 == 5'd0) ? 32'h0 : ((BYP && w && wa != 5'd0 && wa == ra2) ? wd : model[ra2]);
      push_exp($sformatf("random_%0d", it), e1, e2, model_cnt);
      #1;
      e = sb.pop_front();
      n_tests++;
      if (rdata1_out !== e.r1 || rdata2_out !== e.r2 || wr_count_out !== e.cnt) begin
        n_fail++;
        $display("FAIL %s r1=%h r2=%h cnt=%h required r1=%h r2=%h cnt=%h", e.name, rdata1_out, rdata2_out, wr_count_out, e.r1, e.r2, e.cnt);
      end
      @(posedge clk);
      if (w && wa != 5'd0) begin
        model[wa] = wd;
        model_cnt = model_cnt + 32'd1;
      end
    end
    #1 we_in = 1'b0;
  endtask

  task automatic test_counter_wrap();
    exp_t e;
    @(negedge clk);
    force dut.r_wr_count = 32'hFFFFFFFF;
    #1 release dut.r_wr_count;
    model_cnt = 32'hFFFFFFFF;
    do_write(5'd9, 32'h99);
    raddr1_in = 5'd9; raddr2_in = 5'd0;
    push_exp("counter_wrap", 32'h99, 32'h0, model_cnt);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (rdata1_out !== e.r1 || rdata2_out !== e.r2 || wr_count_out !== e.cnt) begin
      n_fail++;
      $display("FAIL %s r1=%h r2=%h cnt=%h required r1=%h r2=%h cnt=%h", e.name, rdata1_out, rdata2_out, wr_count_out, e.r1, e.r2, e.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x0();
    test_hazard();
    test_exec_chain();
    test_random();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
